// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state/operation types and sizing constants
// for the round-robin SRAM arbiter.
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
  typedef enum logic {OP_READ, OP_WRITE} op_e;
  localparam int MAX_CH = 8;
  localparam int IDX_W = 3;
  function automatic int idx_w();
    return IDX_W;
  endfunction
endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first request
// at or above ptr, wrapping modulo N.
module rr_picker
  import sram_arb_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  localparam int SW = IDX_W + 1;
  logic [2*N-1:0] rot;
  logic [SW-1:0] sum;
  always_comb begin
    rot = {req, req} >> ptr;
    sum = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) sum = {1'b0, ptr} + SW'(k);
    idx = IDX_W'(sum >= SW'(N) ? sum - SW'(N) : sum);
  end
  assign valid = |req;
endmodule

// File: rtl/sram_arbiter_rr.sv
// sram_arbiter_rr: round-robin arbiter of N_CPU cores onto one async SRAM,
// with a programmable strobe width and per-channel re-request masking.
module sram_arbiter_rr
  import sram_arb_pkg::*;
#(
  parameter int N_CPU       = 5,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [N_CPU-1:0]        req_we_n,
  input  logic [N_CPU-1:0]        req_oe_n,
  input  logic [N_CPU*ADDR_W-1:0] req_addr,
  input  logic [N_CPU*DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0]       sram_din,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_dout,
  output logic                    sram_drive,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_W-1:0]       rd_data,
  output logic [N_CPU-1:0]        req_done,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick;
  logic [N_CPU-1:0] mask_q, mask_d, req, hit;
  logic [ADDR_W-1:0] addr_q, addr_d, pick_addr;
  logic [DATA_W-1:0] data_q, data_d, rd_data_q, rd_data_d, pick_data;
  logic [3:0] cnt_q, cnt_d;
  logic pick_vld, pick_wr;
  assign req = (~req_we_n | ~req_oe_n) & ~mask_q;
  assign hit = N_CPU'(1) << grant_id_q;
  rr_picker #(.N(N_CPU)) u_pick (
    .req  (req),
    .ptr  (rr_ptr_q),
    .idx  (pick),
    .valid(pick_vld)
  );
  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    pick_wr = 1'b0;
    for (int i = 0; i < N_CPU; i++)
      if (pick == IDX_W'(i)) begin
        pick_addr = req_addr[i*ADDR_W +: ADDR_W];
        pick_data = req_data[i*DATA_W +: DATA_W];
        pick_wr = ~req_we_n[i];
      end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    addr_d = addr_q;
    data_d = data_q;
    rd_data_d = rd_data_q;
    cnt_d = cnt_q;
    // release clears the mask in every state; DONE's set below takes priority
    mask_d = mask_q & ~(req_we_n & req_oe_n);
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = SETUP;
        grant_id_d = pick;
        op_d = pick_wr ? OP_WRITE : OP_READ;
        addr_d = pick_addr;
        data_d = pick_data;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d = 4'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          rd_data_d = op_q == OP_READ ? sram_din : rd_data_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        mask_d = mask_d | hit;
        rr_ptr_d = grant_id_q == IDX_W'(N_CPU - 1) ? '0 : grant_id_q + 1'b1;
      end
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      op_q <= OP_READ;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      mask_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rd_data_q <= rd_data_d;
      cnt_q <= cnt_d;
    end
  assign busy = state_q != IDLE;
  assign sram_ce_n = !(state_q == SETUP || state_q == ACCESS);
  assign sram_oe_n = !(state_q == ACCESS && op_q == OP_READ);
  assign sram_we_n = !(state_q == ACCESS && op_q == OP_WRITE);
  assign sram_drive = !sram_ce_n && op_q == OP_WRITE;
  assign sram_addr = addr_q;
  assign sram_dout = data_q;
  assign rd_data = rd_data_q;
  assign grant_id = grant_id_q;
  assign req_done = state_q == DONE ? hit : '0;
endmodule
